// File: rtl/spi_dev_proto_if.sv
// Handler-side bus of the SPI device protocol wrapper: byte broadcast,
// frame-end notification, grant handshake and per-handler read bytes.
interface spi_dev_proto_if #(
  parameter int N_PORTS = 2
);
  logic [7:0]           pw_wdata;
  logic                 pw_wcmd;
  logic                 pw_wstb;
  logic                 pw_end;
  logic [N_PORTS-1:0]   pw_req;
  logic [N_PORTS-1:0]   pw_gnt;
  logic [8*N_PORTS-1:0] pw_rdata;
  logic [N_PORTS-1:0]   pw_rstb;

  // Wrapper side: drives broadcast and grant, receives requests and read bytes.
  modport master (
    output pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt,
    input  pw_req, pw_rdata, pw_rstb
  );

  // Handler side: the mirror image of the wrapper view.
  modport slave (
    input  pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_gnt,
    output pw_req, pw_rdata, pw_rstb
  );
endinterface

// File: rtl/spi_dev_proto.sv
// Protocol wrapper between the byte-level SPI device core and N command
// handlers. Every received byte is broadcast to all handlers, the first byte
// of a CS frame is flagged as the command byte, one requesting handler is
// granted per frame, and the granted handler's read bytes are queued in a
// small FIFO feeding the core's TX path.
module spi_dev_proto #(
  parameter int         N_PORTS   = 2,
  parameter int         TX_DEPTH  = 8,
  parameter logic [7:0] FILL_BYTE = 8'hff
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     sc_rx_data,
  input  logic           sc_rx_stb,
  input  logic           sc_rx_first,
  input  logic           sc_cs_end,
  output logic [7:0]     sc_tx_data,
  input  logic           sc_tx_ack,
  output logic           stat_tx_ovf,
  spi_dev_proto_if.master pw
);

  localparam int AW = $clog2(TX_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(TX_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_GRANTED = 1'b1
  } state_e;

  // Fixed-priority pick: one-hot of the lowest-index set request bit.
  function automatic logic [N_PORTS-1:0] lowest_onehot(input logic [N_PORTS-1:0] req);
    logic [N_PORTS-1:0] oh;
    logic               found;
    oh    = '0;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (req[i] && !found) begin
        oh[i] = 1'b1;
        found = 1'b1;
      end else begin
        oh[i] = 1'b0;
      end
    end
    return oh;
  endfunction

  // RX broadcast registers
  logic [7:0]         wdata_r;
  logic               wcmd_r;
  logic               wstb_r;
  logic               end_r;

  // Grant FSM
  state_e             state_r;
  state_e             state_s;
  logic [N_PORTS-1:0] gnt_r;
  logic [N_PORTS-1:0] gnt_s;

  // TX FIFO
  logic [7:0]         mem_r [TX_DEPTH];
  logic [AW-1:0]      wp_r;
  logic [AW-1:0]      rp_r;
  logic [AW:0]        cnt_r;
  logic [AW-1:0]      wp_s;
  logic [AW-1:0]      rp_s;
  logic [AW:0]        cnt_s;
  logic [7:0]         tx_data_r;
  logic [7:0]         head_s;
  logic               ovf_r;

  logic [7:0]         rdata_s;
  logic               rstb_sel_s;
  logic               push_s;
  logic               pop_s;
  logic               full_s;
  logic               wr_s;
  logic               drop_s;

  assign pw.pw_wdata = wdata_r;
  assign pw.pw_wcmd  = wcmd_r;
  assign pw.pw_wstb  = wstb_r;
  assign pw.pw_end   = end_r;
  assign pw.pw_gnt   = gnt_r;
  assign sc_tx_data  = tx_data_r;
  assign stat_tx_ovf = ovf_r;

  // RX path: one-cycle registered broadcast of bytes and the frame-end pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wdata_r <= 8'h00;
      wcmd_r  <= 1'b0;
      wstb_r  <= 1'b0;
      end_r   <= 1'b0;
    end else begin
      wstb_r <= sc_rx_stb;
      wcmd_r <= sc_rx_stb & sc_rx_first;
      end_r  <= sc_cs_end;
      if (sc_rx_stb) begin
        wdata_r <= sc_rx_data;
      end
    end
  end

  // Grant FSM state and grant vector registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      gnt_r   <= '0;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
    end
  end

  // Grant FSM next state: a frame end in IDLE suppresses a new grant that
  // cycle; once granted, the owner keeps the grant until the frame ends.
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    case (state_r)
      ST_IDLE: begin
        if (end_r) begin
          state_s = ST_IDLE;
          gnt_s   = '0;
        end else if (|pw.pw_req) begin
          state_s = ST_GRANTED;
          gnt_s   = lowest_onehot(pw.pw_req);
        end else begin
          state_s = ST_IDLE;
          gnt_s   = '0;
        end
      end
      ST_GRANTED: begin
        if (end_r) begin
          state_s = ST_IDLE;
          gnt_s   = '0;
        end else begin
          state_s = ST_GRANTED;
          gnt_s   = gnt_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = '0;
      end
    endcase
  end

  // Select the granted port's read byte and strobe (AND-OR mux on the one-hot grant).
  always_comb begin
    rdata_s = 8'h00;
    for (int i = 0; i < N_PORTS; i++) begin
      rdata_s = rdata_s | (pw.pw_rdata[8*i +: 8] & {8{gnt_r[i]}});
    end
    rstb_sel_s = |(pw.pw_rstb & gnt_r);
  end

  // FIFO control: frame end flushes and swallows any simultaneous push;
  // a push onto a full FIFO is accepted only when a pop frees a slot.
  always_comb begin
    push_s = (state_r == ST_GRANTED) && rstb_sel_s && !end_r;
    pop_s  = sc_tx_ack && (cnt_r != '0) && !end_r;
    full_s = (cnt_r == DEPTH_C);
    wr_s   = push_s && (!full_s || pop_s);
    drop_s = push_s && full_s && !pop_s;
    if (end_r) begin
      wp_s  = '0;
      rp_s  = '0;
      cnt_s = '0;
    end else begin
      wp_s  = wp_r + {{(AW-1){1'b0}}, wr_s};
      rp_s  = rp_r + {{(AW-1){1'b0}}, pop_s};
      cnt_s = cnt_r + {{AW{1'b0}}, wr_s} - {{AW{1'b0}}, pop_s};
    end
  end

  // Next TX byte: the post-update FIFO head, bypassing the byte being
  // written when it lands in the head slot, or the fill byte when empty.
  always_comb begin
    head_s = FILL_BYTE;
    if (cnt_s == '0) begin
      head_s = FILL_BYTE;
    end else if (wr_s && (wp_r == rp_s)) begin
      head_s = rdata_s;
    end else begin
      head_s = mem_r[rp_s];
    end
  end

  // FIFO storage write; contents need no reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wp_r] <= rdata_s;
    end
  end

  // FIFO pointers, occupancy, registered TX byte and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_r      <= '0;
      rp_r      <= '0;
      cnt_r     <= '0;
      tx_data_r <= FILL_BYTE;
      ovf_r     <= 1'b0;
    end else begin
      wp_r      <= wp_s;
      rp_r      <= rp_s;
      cnt_r     <= cnt_s;
      tx_data_r <= head_s;
      ovf_r     <= drop_s;
    end
  end

endmodule
